// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick-driven timer blocks: state encoding,
// default widths and a decoder that folds the unused state code onto IDLE.
package tick_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_EXPW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // The fourth encoding is never written, but if it ever appears the timer
  // behaves as if it were idle so it cannot get stuck.
  function automatic state_e decodeState(input logic [1:0] raw);
    case (raw)
      2'd1:    return ST_RUN;
      2'd2:    return ST_PAUSE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_downcounter_sat_counter.sv
// Saturating up-counter used to count timer expiries. A clear takes
// priority over an increment; clearing and incrementing together leaves
// the counter at one, which is how a zero-length start records its expiry.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count up on request, stick at all-ones, restart on clear.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= inc_i ? W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tick_downcounter.sv
// Programmable down-counting timer. A start loads the count, each tick in
// RUN decrements it, and reaching zero pulses done and either returns to
// IDLE or reloads for periodic operation. Expiries are tallied in a
// saturating counter that restarts on every accepted start.
module tick_downcounter
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int EXPW  = DEFAULT_EXPW
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [EXPW-1:0]  exp_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reloadVal_q, reloadVal_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             expClr, expInc;

  // Next-state and datapath decisions, honouring stop > start > pause > tick.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reloadVal_d = reloadVal_q;
    periodic_d  = periodic_q;
    done_d      = 1'b0;
    expClr      = 1'b0;
    expInc      = 1'b0;

    case (decodeState(state_q))
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            expInc = 1'b1;
            if (periodic_q) begin
              count_d = reloadVal_q;
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        if (stop) begin
          count_d = '0;
        end else if (start) begin
          expClr = 1'b1;
          if (load_val != '0) begin
            count_d     = load_val;
            reloadVal_d = load_val;
            periodic_d  = auto_reload;
            state_d     = ST_RUN;
          end else begin
            count_d = '0;
            expInc  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // State, datapath and registered outputs all update on the same edge.
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      reloadVal_q <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reloadVal_q <= reloadVal_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  sat_counter #(
    .W(EXPW)
  ) u_expCounter (
    .Clock   (Clock),
    .rst     (rst),
    .clr_i   (expClr),
    .inc_i   (expInc),
    .count_o (exp_cnt)
  );

  assign Q    = count_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tick_downcounter.sv
// Directed bench for tick_downcounter. Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point, so every value is
// observed well away from the active edge.
module tb_tick_downcounter;

  logic       Clock = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] load_val;
  logic       auto_reload;
  logic       pause;
  logic       stop;
  logic [7:0] Q;
  logic       busy;
  logic       done;
  logic [7:0] exp_cnt;
  logic [7:0] Q2;
  logic       busy2;
  logic       done2;
  logic [1:0] expCnt2;

  int compared   = 0;
  int mismatched = 0;

  tick_downcounter #(.WIDTH(8), .EXPW(8)) dut (
    .Clock(Clock), .rst(rst), .tick(tick), .start(start),
    .load_val(load_val), .auto_reload(auto_reload), .pause(pause),
    .stop(stop), .Q(Q), .busy(busy), .done(done), .exp_cnt(exp_cnt)
  );

  tick_downcounter #(.WIDTH(8), .EXPW(2)) dutSat (
    .Clock(Clock), .rst(rst), .tick(tick), .start(start),
    .load_val(load_val), .auto_reload(auto_reload), .pause(pause),
    .stop(stop), .Q(Q2), .busy(busy2), .done(done2), .exp_cnt(expCnt2)
  );

  // Free-running clock, period 10.
  always #5 Clock = ~Clock;

  // Advance n clock edges and settle just after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic test_reset();
    applyStimulus(2);
    compared++;
    if (Q !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || exp_cnt !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset: Q=%0d busy=%0b done=%0b exp=%0d expected 0/0/0/0", Q, busy, done, exp_cnt);
    end
    compared++;
    if (Q2 !== 8'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || expCnt2 !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_sat: Q=%0d busy=%0b done=%0b exp=%0d expected 0/0/0/0", Q2, busy2, done2, expCnt2);
    end
    rst = 1'b1;
    applyStimulus(1);
  endtask

  task automatic test_oneshot();
    start = 1'b1; load_val = 8'd5; auto_reload = 1'b0;
    applyStimulus(1);
    start = 1'b0;
    compared++;
    if (Q !== 8'd5 || busy !== 1'b1 || exp_cnt !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL oneshot_load: Q=%0d busy=%0b exp=%0d expected 5/1/0", Q, busy, exp_cnt);
    end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(2);
      tick = 1'b1;
      applyStimulus(1);
      tick = 1'b0;
      compared++;
      if (Q !== 8'(5 - i) || done !== (i == 5)) begin
        mismatched++;
        $display("[TB] FAIL oneshot_tick%0d: Q=%0d done=%0b expected %0d/%0b", i, Q, done, 5 - i, (i == 5));
      end
    end
    applyStimulus(1);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || exp_cnt !== 8'd1 || Q !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL oneshot_end: done=%0b busy=%0b exp=%0d Q=%0d expected 0/0/1/0", done, busy, exp_cnt, Q);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] expQ [10]    = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2};
    logic       expDone [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    start = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
    applyStimulus(1);
    start = 1'b0; auto_reload = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1;
      applyStimulus(1);
      compared++;
      if (Q !== expQ[i] || done !== expDone[i] || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL periodic_tick%0d: Q=%0d done=%0b busy=%0b expected %0d/%0b/1", i + 1, Q, done, busy, expQ[i], expDone[i]);
      end
    end
    tick = 1'b0;
    compared++;
    if (exp_cnt !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL periodic_expcnt: got %0d expected 3", exp_cnt);
    end
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    compared++;
    if (Q !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || exp_cnt !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL periodic_stop: Q=%0d busy=%0b done=%0b exp=%0d expected 0/0/0/3", Q, busy, done, exp_cnt);
    end
  endtask

  task automatic test_pause_stop();
    start = 1'b1; load_val = 8'd4;
    applyStimulus(1);
    start = 1'b0;
    tick = 1'b1;
    applyStimulus(1);
    tick = 1'b0;
    compared++;
    if (Q !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL pause_first_tick: Q=%0d expected 3", Q);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      applyStimulus(1);
      tick = 1'b0;
      applyStimulus(1);
    end
    compared++;
    if (Q !== 8'd3 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pause_hold: Q=%0d busy=%0b expected 3/1", Q, busy);
    end
    pause = 1'b0; tick = 1'b1;
    applyStimulus(1);
    compared++;
    if (Q !== 8'd3) begin
      mismatched++;
      $display("[TB] FAIL pause_release_tick: Q=%0d expected 3", Q);
    end
    applyStimulus(1);
    compared++;
    if (Q !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL pause_resume: Q=%0d expected 2", Q);
    end
    applyStimulus(1);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0; tick = 1'b0;
    compared++;
    if (Q !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || exp_cnt !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL stop_vs_expiry: Q=%0d done=%0b busy=%0b exp=%0d expected 0/0/0/0", Q, done, busy, exp_cnt);
    end
  endtask

  task automatic test_zero_load();
    start = 1'b1; load_val = 8'd0; auto_reload = 1'b1;
    applyStimulus(1);
    start = 1'b0; auto_reload = 1'b0;
    compared++;
    if (Q !== 8'd0 || done !== 1'b1 || busy !== 1'b0 || exp_cnt !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL zero_load: Q=%0d done=%0b busy=%0b exp=%0d expected 0/1/0/1", Q, done, busy, exp_cnt);
    end
    applyStimulus(1);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_load_after: done=%0b busy=%0b expected 0/0", done, busy);
    end
  endtask

  task automatic test_start_boundaries();
    start = 1'b1; load_val = 8'd6; tick = 1'b1;
    applyStimulus(1);
    start = 1'b0; tick = 1'b0;
    compared++;
    if (Q !== 8'd6 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL start_with_tick: Q=%0d busy=%0b expected 6/1", Q, busy);
    end
    start = 1'b1; load_val = 8'd9;
    applyStimulus(1);
    start = 1'b0;
    compared++;
    if (Q !== 8'd6) begin
      mismatched++;
      $display("[TB] FAIL start_in_run: Q=%0d expected 6", Q);
    end
    tick = 1'b1;
    applyStimulus(1);
    tick = 1'b0;
    compared++;
    if (Q !== 8'd5) begin
      mismatched++;
      $display("[TB] FAIL run_after_ignored_start: Q=%0d expected 5", Q);
    end
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
  endtask

  task automatic test_full_range();
    start = 1'b1; load_val = 8'd255;
    applyStimulus(1);
    start = 1'b0;
    compared++;
    if (Q !== 8'd255) begin
      mismatched++;
      $display("[TB] FAIL full_load: Q=%0d expected 255", Q);
    end
    tick = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1);
      compared++;
      if (Q !== 8'(255 - i) || done !== (i == 255)) begin
        mismatched++;
        $display("[TB] FAIL full_tick%0d: Q=%0d done=%0b expected %0d/%0b", i, Q, done, 255 - i, (i == 255));
      end
    end
    applyStimulus(1);
    tick = 1'b0;
    compared++;
    if (Q !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || exp_cnt !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL full_no_wrap: Q=%0d done=%0b busy=%0b exp=%0d expected 0/0/0/1", Q, done, busy, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; load_val = 8'd9;
    applyStimulus(1);
    start = 1'b0;
    tick = 1'b1;
    applyStimulus(2);
    tick = 1'b0;
    compared++;
    if (Q !== 8'd7) begin
      mismatched++;
      $display("[TB] FAIL areset_pre: Q=%0d expected 7", Q);
    end
    #3 rst = 1'b0;
    #1;
    compared++;
    if (Q !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || exp_cnt !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL areset_mid: Q=%0d busy=%0b done=%0b exp=%0d expected 0/0/0/0", Q, busy, done, exp_cnt);
    end
    #1 rst = 1'b1;
    start = 1'b1; load_val = 8'd2;
    applyStimulus(1);
    start = 1'b0;
    compared++;
    if (Q !== 8'd2 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL areset_restart: Q=%0d busy=%0b expected 2/1", Q, busy);
    end
    tick = 1'b1;
    applyStimulus(2);
    tick = 1'b0;
    compared++;
    if (Q !== 8'd0 || done !== 1'b1 || exp_cnt !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL areset_expiry: Q=%0d done=%0b exp=%0d expected 0/1/1", Q, done, exp_cnt);
    end
    applyStimulus(1);
  endtask

  task automatic test_saturation();
    int expSat [6] = '{1, 2, 3, 3, 3, 3};
    start = 1'b1; load_val = 8'd1; auto_reload = 1'b1;
    applyStimulus(1);
    start = 1'b0; auto_reload = 1'b0;
    compared++;
    if (Q2 !== 8'd1 || busy2 !== 1'b1 || expCnt2 !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL sat_load: Q=%0d busy=%0b exp=%0d expected 1/1/0", Q2, busy2, expCnt2);
    end
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      compared++;
      if (Q2 !== 8'd1 || done2 !== 1'b1 || expCnt2 !== 2'(expSat[i])) begin
        mismatched++;
        $display("[TB] FAIL sat_tick%0d: Q=%0d done=%0b exp=%0d expected 1/1/%0d", i + 1, Q2, done2, expCnt2, expSat[i]);
      end
    end
    tick = 1'b0;
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    compared++;
    if (busy2 !== 1'b0 || expCnt2 !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL sat_stop: busy=%0b exp=%0d expected 0/3", busy2, expCnt2);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; load_val = 8'd0;
    auto_reload = 1'b0; pause = 1'b0; stop = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_stop();
    test_zero_load();
    test_start_boundaries();
    test_full_range();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tick_downcounter.md
# tick_downcounter

Programmable down-counting timer driven by a single-cycle tick enable, normally the TC pulse of the free-running modulo prescaler. It loads a count and decrements once per tick. It flags expiry with a one-cycle `done` pulse, and optionally reloads for periodic operation. It is the consumer end of the prescaler's TC output, turning the base tick rate into software-visible timeouts and periodic events.

## Interface
- `WIDTH`, 8: width of the count, load value and reload register.
- `EXPW`, 8: width of the saturating expiry counter.
- `Clock` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-low. Asserting it forces the reset state immediately.
- `tick` input 1: decrement enable, one Clock cycle wide (prescaler TC).
- `start` input 1: load `load_val` and begin counting.
- `load_val` input WIDTH: initial count and reload value, sampled only when a start is accepted.
- `auto_reload` input 1: periodic mode, sampled only when a start is accepted.
- `pause` input 1: level; while high, ticks are ignored in RUN.
- `stop` input 1: abort to IDLE.
- `Q` output WIDTH: current count, registered.
- `busy` output 1: high in RUN or PAUSE.
- `done` output 1: one-cycle expiry pulse, registered.
- `exp_cnt` output EXPW: number of expiries since the last accepted start. Saturates at all-ones.

## Operation
- **States:** IDLE, RUN, PAUSE.
- **Reset values:** state IDLE, `Q`=0, `busy`=0, `done`=0, `exp_cnt`=0, reload register 0, mode bit 0.
- **Input priority each cycle:** `stop` > `start` > `pause` > `tick`.
- **IDLE:**
  - `start` with `load_val`≠0: `Q`←`load_val`, reload register←`load_val`, mode←`auto_reload`, `exp_cnt`←0, go to RUN.
  - `start` with `load_val`=0: `Q`←0, `exp_cnt`←1, pulse `done` next cycle, stay IDLE regardless of `auto_reload`.
  - `tick` in IDLE: ignored.
- **RUN:**
  - `pause`=1: go to PAUSE; a `tick` in that cycle is ignored.
  - `tick` with `Q`>1: `Q`←`Q`−1.
  - `tick` with `Q`=1 (expiry):
    - `done` pulses.
    - `exp_cnt` increments, saturating.
    - Mode=0: `Q`←0, go to IDLE.
    - Mode=1: `Q`←reload register, stay in RUN.
  - `start` in RUN: ignored (no restart).
- **PAUSE:**
  - `Q` held; ticks ignored.
  - `pause`=0: return to RUN. A `tick` in that same cycle is not counted; counting resumes on the next tick.
  - `start` in PAUSE: ignored.
- **`stop` (any state):** go to IDLE, `Q`←0, no `done`. `exp_cnt` is held.
- **Underflow:** `Q` never wraps below 0. All arithmetic is WIDTH-bit unsigned.
- **`busy`:** registered, equals (state≠IDLE) after each edge.

## Timing
- **Load latency:** `start` sampled at edge N; `Q`=`load_val` and `busy`=1 visible after edge N.
- **Tick coincident with accepted `start`:** not counted; the first decrement is on the next tick.
- **Expiry:** the tick sampled at edge N where `Q`=1 gives `Q`=0 (or reload value) and `done`=1 after edge N. `done` deasserts after edge N+1.
- **Periodic mode:** the period is exactly `load_val` ticks between consecutive `done` pulses.
- **`stop` and expiring tick at the same edge:** stop wins; no `done` and `exp_cnt` unchanged.
- **Reset mid-count:** outputs go to reset values asynchronously; a `done` in flight is dropped.

## Structure
- **Shared package `tick_timer_pkg`:** state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and default WIDTH/EXPW values. The unused encoding decodes to IDLE.
- **Sub-module `sat_counter` (width parameter; clear, increment, async active-low reset):** implements `exp_cnt`.
- **Main block:** the FSM, count/reload datapath, and output registers.

## Test plan
- **Reset then one-shot:** release `rst`, `start` with `load_val`=5, 5 ticks spaced 3 cycles apart → `Q` steps 5,4,3,2,1,0. `done` is high for exactly one cycle after the 5th tick, then `busy`=0 and `exp_cnt`=1.
- **Periodic:** `load_val`=3, `auto_reload`=1, 10 ticks → `done` after ticks 3, 6 and 9, `Q` reloads to 3 each time, `exp_cnt`=3, `busy` stays 1.
- **Pause/stop:** `load_val`=4, 1 tick (`Q`=3), hold `pause` across 4 ticks → `Q` stays 3. Release `pause`, 1 tick → `Q`=2. Assert `stop` together with a tick → `Q`=0, no `done`, `busy`=0.
- **Boundaries:**
  - `start` with `load_val`=0 → single `done`, stays IDLE.
  - `start` together with a tick → `Q`=`load_val`, not `load_val`−1.
  - `start` during RUN → ignored.
  - `load_val`=255 counts down fully to 0 without wrap.
- **Async reset mid-count:** assert `rst` between edges at `Q`=7 → `Q`=0, `busy`=0, `done`=0 before the next edge. After release, a new `start` behaves normally.
- **Saturation:** EXPW=2, periodic with `load_val`=1, 6 ticks → `exp_cnt` sticks at 3.
